// File: rtl/cyx_multicycle_ctrl.sv
// Multi-cycle control FSM for the nanoMIPS datapath: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Latency: j 2, beq 3, R 4, sw 4, lw 5 cycles with mem_ready=1; each memory wait cycle adds 1.
// Backpressure: FETCH and MEM hold their memory request steady until mem_ready completes the access.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode, funct     instruction fields from the IR
//   zero              ALU zero flag (same cycle)
//   mem_ready         shared memory port completes the current access this cycle
//   pc_wr, pc_src     PC load enable / source (00 PC+4, 01 ALUOut, 10 jump target)
//   ir_wr, iord       IR load enable / memory address select (0 PC, 1 ALUOut)
//   mem_rd, mem_wr    memory read / write request
//   reg_dst, reg_wr, mem_to_reg   register file destination, write enable, write-data select
//   alu_src_a, alu_src_b, ext_op, alu_ctr   ALU operand selects, imm16 extension, operation
//   illegal           one-cycle pulse for an unsupported opcode/funct seen in DECODE
//   state             current state for debug (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4)
//
// Build option: define CYX_MC_ADDI_EN to make opcode 8 (addi) a legal instruction.

module cyx_multicycle_ctrl #(
  parameter int ALUCTR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_wr,
  output logic [1:0]          pc_src,
  output logic                ir_wr,
  output logic                iord,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                reg_dst,
  output logic                reg_wr,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_op,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                illegal,
  output logic [2:0]          state
);

  localparam logic [ALUCTR_W-1:0] ALU_ADD = ALUCTR_W'(4'b0010);
  localparam logic [ALUCTR_W-1:0] ALU_SUB = ALUCTR_W'(4'b0110);
  localparam logic [ALUCTR_W-1:0] ALU_AND = ALUCTR_W'(4'b0000);
  localparam logic [ALUCTR_W-1:0] ALU_OR  = ALUCTR_W'(4'b0001);
  localparam logic [ALUCTR_W-1:0] ALU_SLT = ALUCTR_W'(4'b0111);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t cur_state, nxt_state;

  logic is_r, r_legal, is_j, is_beq, is_lw, is_sw, is_addi;
  logic [ALUCTR_W-1:0] r_alu;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= nxt_state;
  end

  // The debug view reads FETCH for the whole reset cycle, even before the register updates.
  assign state = rst ? 3'd0 : cur_state;

  // Instruction class decode
  always_comb begin
    is_r   = (opcode == OP_R);
    is_j   = (opcode == OP_J);
    is_beq = (opcode == OP_BEQ);
    is_lw  = (opcode == OP_LW);
    is_sw  = (opcode == OP_SW);
`ifdef CYX_MC_ADDI_EN
    is_addi = (opcode == OP_ADDI);
`else
    is_addi = 1'b0;
`endif
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (funct)
      6'd32:   r_alu = ALU_ADD;
      6'd34:   r_alu = ALU_SUB;
      6'd36:   r_alu = ALU_AND;
      6'd37:   r_alu = ALU_OR;
      6'd42:   r_alu = ALU_SLT;
      default: r_legal = 1'b0;
    endcase
  end

  // Next state and datapath controls
  always_comb begin
    nxt_state  = cur_state;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    ir_wr      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = 1'b0;
    reg_wr     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 1'b0;
    alu_ctr    = ALU_ADD;
    illegal    = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target PC + (sext(imm16)<<2) is computed speculatively into ALUOut.
        alu_src_b = 2'b11;
        if (is_j) begin
          pc_wr     = 1'b1;
          pc_src    = 2'b10;
          nxt_state = S_FETCH;
        end else if ((is_r && r_legal) || is_lw || is_sw || is_beq || is_addi) begin
          nxt_state = S_EXEC;
        end else begin
          illegal   = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        nxt_state = S_FETCH;
        if (is_r) begin
          alu_ctr   = r_alu;
          nxt_state = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
          nxt_state = S_MEM;
        end else if (is_beq) begin
          alu_ctr = ALU_SUB;
          pc_src  = 2'b01;
          pc_wr   = zero;
        end else if (is_addi) begin
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        mem_rd = is_lw;
        mem_wr = is_sw;
        if (mem_ready) nxt_state = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        nxt_state  = S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase

    // Architectural side effects are suppressed in the reset cycle so an abandoned
    // instruction never leaves a partial write behind.
    if (rst) begin
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule
